// File: rtl/keypad_debounce_ctrl_if.sv
// Keypad front-end bundle: raw key lines and enable toward the controller,
// encoded digit, strobe and status flags back to the time-entry logic.
interface keypad_debounce_ctrl_if #(
  parameter int NKEYS = 10
);
  logic             enable;
  logic [NKEYS-1:0] keys;
  logic [3:0]       code;
  logic             valid;
  logic             pressed;
  logic             multi;

  modport master (
    output enable, keys,
    input  code, valid, pressed, multi
  );

  modport slave (
    input  enable, keys,
    output code, valid, pressed, multi
  );
endinterface

// File: rtl/keypad_debounce_ctrl.sv
// Microwave keypad controller: qualifies a stable key pattern, emits one
// priority-encoded digit strobe per press, then waits for a debounced release.
module keypad_debounce_ctrl #(
  parameter int NKEYS    = 10,
  parameter int DEBOUNCE = 3
) (
  input  logic                  clk,
  input  logic                  clear,
  keypad_debounce_ctrl_if.slave kp
);

  localparam int             CW   = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_EMIT     = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  state_t           r_state;
  logic [NKEYS-1:0] r_sample;
  logic [CW-1:0]    r_count;
  logic [3:0]       r_code;
  logic             r_valid;
  logic             r_pressed;
  logic             r_multi;

  logic [NKEYS-1:0] w_keys;
  logic             w_keys_any;
  logic             w_keys_match;

  // Lowest set index wins, so scan from the top and let lower bits overwrite.
  function automatic logic [3:0] lowest_index(input logic [NKEYS-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic several_set(input logic [NKEYS-1:0] v);
    return |(v & (v - {{(NKEYS-1){1'b0}}, 1'b1}));
  endfunction

  assign w_keys       = kp.keys;
  assign w_keys_any   = |w_keys;
  assign w_keys_match = (w_keys == r_sample);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_sample  <= '0;
      r_count   <= '0;
      r_code    <= 4'd0;
      r_valid   <= 1'b0;
      r_pressed <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (kp.enable && w_keys_any) begin
            r_sample  <= w_keys;
            r_count   <= '0;
            r_pressed <= 1'b1;
            r_state   <= S_DEBOUNCE;
          end else begin
            r_count <= '0;
          end
        end
        S_DEBOUNCE: begin
          if (!kp.enable || !w_keys_match) begin
            r_count   <= '0;
            r_pressed <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_count == LAST) begin
            r_valid <= 1'b1;
            r_code  <= lowest_index(r_sample);
            r_multi <= several_set(r_sample);
            r_state <= S_EMIT;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_EMIT: begin
          r_count <= '0;
          r_state <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          // enable is deliberately ignored here so a held key cannot re-trigger
          if (w_keys_any) begin
            r_count <= '0;
          end else if (r_count == LAST) begin
            r_count   <= '0;
            r_pressed <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: begin
          r_count   <= '0;
          r_pressed <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign kp.code    = r_code;
  assign kp.valid   = r_valid;
  assign kp.pressed = r_pressed;
  assign kp.multi   = r_multi;

endmodule

// File: tb/tb_keypad_debounce_ctrl.sv
// Self-checking bench for keypad_debounce_ctrl: directed scenarios plus random
// key traffic, each cycle compared against a run-length reference model.
module tb_keypad_debounce_ctrl;

  localparam int NKEYS    = 10;
  localparam int DEBOUNCE = 3;

  logic clk = 1'b0;
  logic clear;
  int   errors = 0;
  int   checks = 0;

  keypad_debounce_ctrl_if #(.NKEYS(NKEYS)) kif ();

  keypad_debounce_ctrl #(.NKEYS(NKEYS), .DEBOUNCE(DEBOUNCE)) dut (
    .clk   (clk),
    .clear (clear),
    .kp    (kif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: press accepted after DEBOUNCE matching samples following
  // the capture sample; release after DEBOUNCE consecutive all-zero samples.
  bit               m_busy, m_accepted, m_emit_cycle;
  int               m_match, m_zero_run;
  logic [NKEYS-1:0] m_sample;
  logic [3:0]       e_code;
  logic             e_valid, e_pressed, e_multi;

  task automatic model_step(input logic [NKEYS-1:0] k, input logic en, input logic clr);
    bit found;
    e_valid = 1'b0;
    if (clr) begin
      m_busy = 0; m_accepted = 0; m_emit_cycle = 0; m_match = 0; m_zero_run = 0;
      m_sample = '0; e_code = 4'd0; e_multi = 1'b0;
    end else if (!m_busy) begin
      if (en && k != '0) begin
        m_busy = 1; m_sample = k; m_match = 0;
      end
    end else if (!m_accepted) begin
      if (!en || k != m_sample) begin
        m_busy = 0;
      end else begin
        m_match++;
        if (m_match == DEBOUNCE) begin
          found = 0;
          for (int i = 0; i < NKEYS; i++) begin
            if (!found && m_sample[i]) begin
              e_code = 4'(i);
              found  = 1;
            end
          end
          e_multi      = ($countones(m_sample) > 1);
          e_valid      = 1'b1;
          m_accepted   = 1;
          m_emit_cycle = 1;
        end
      end
    end else if (m_emit_cycle) begin
      m_emit_cycle = 0;
      m_zero_run   = 0;
    end else begin
      if (k != '0) begin
        m_zero_run = 0;
      end else begin
        m_zero_run++;
        if (m_zero_run == DEBOUNCE) begin
          m_busy = 0; m_accepted = 0;
        end
      end
    end
    e_pressed = m_busy;
  endtask

  task automatic tick(input logic [NKEYS-1:0] k, input logic en, input logic clr);
    kif.keys   = k;
    kif.enable = en;
    clear      = clr;
    @(posedge clk);
    model_step(k, en, clr);
    #1;
  endtask

  task automatic test_reset();
    for (int t = 0; t < 3; t++) begin
      tick(10'h3FF, 1'b1, 1'b1);
      checks++;
      if ({kif.valid, kif.pressed, kif.multi, kif.code} !== 7'd0) begin
        errors++;
        $display("FAIL reset t=%0d got v=%b p=%b m=%b c=%0d want all zero",
                 t, kif.valid, kif.pressed, kif.multi, kif.code);
      end
    end
    tick(10'h000, 1'b1, 1'b0);
    checks++;
    if ({kif.valid, kif.pressed, kif.multi, kif.code} !== {e_valid, e_pressed, e_multi, e_code}) begin
      errors++;
      $display("FAIL reset_idle got %b%b%b/%0d want %b%b%b/%0d", kif.valid, kif.pressed,
               kif.multi, kif.code, e_valid, e_pressed, e_multi, e_code);
    end
  endtask

  task automatic test_single_press();
    int strobes = 0;
    for (int t = 0; t < 18; t++) begin
      tick((t < 10) ? 10'h020 : 10'h000, 1'b1, 1'b0);
      checks++;
      if ({kif.valid, kif.pressed, kif.multi, kif.code} !== {e_valid, e_pressed, e_multi, e_code}) begin
        errors++;
        $display("FAIL single_model t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, kif.valid,
                 kif.pressed, kif.multi, kif.code, e_valid, e_pressed, e_multi, e_code);
      end
      if (kif.valid === 1'b1) strobes++;
      if (t == 3) begin
        checks++;
        if (kif.valid !== 1'b1 || kif.code !== 4'd5 || kif.multi !== 1'b0) begin
          errors++;
          $display("FAIL single_strobe got v=%b c=%0d m=%b want v=1 c=5 m=0",
                   kif.valid, kif.code, kif.multi);
        end
      end
      if (t == 11 || t == 12) begin
        checks++;
        if (kif.pressed !== (t == 11)) begin
          errors++;
          $display("FAIL single_release t=%0d got pressed=%b want %b", t, kif.pressed, t == 11);
        end
      end
    end
    checks++;
    if (strobes != 1) begin
      errors++;
      $display("FAIL single_count got %0d strobes want 1", strobes);
    end
  endtask

  task automatic test_bounce();
    int strobes = 0;
    logic [NKEYS-1:0] k;
    for (int t = 0; t < 18; t++) begin
      k = (t == 2 || t >= 11) ? 10'h000 : 10'h004;
      tick(k, 1'b1, 1'b0);
      checks++;
      if ({kif.valid, kif.pressed, kif.multi, kif.code} !== {e_valid, e_pressed, e_multi, e_code}) begin
        errors++;
        $display("FAIL bounce_model t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, kif.valid,
                 kif.pressed, kif.multi, kif.code, e_valid, e_pressed, e_multi, e_code);
      end
      if (kif.valid === 1'b1) begin
        strobes++;
        checks++;
        if (t != 6 || kif.code !== 4'd2) begin
          errors++;
          $display("FAIL bounce_strobe t=%0d code=%0d want t=6 code=2", t, kif.code);
        end
      end
    end
    checks++;
    if (strobes != 1) begin
      errors++;
      $display("FAIL bounce_count got %0d strobes want 1", strobes);
    end
  endtask

  task automatic test_simultaneous();
    int strobes = 0;
    for (int t = 0; t < 16; t++) begin
      tick((t < 8) ? 10'h090 : 10'h000, 1'b1, 1'b0);
      checks++;
      if ({kif.valid, kif.pressed, kif.multi, kif.code} !== {e_valid, e_pressed, e_multi, e_code}) begin
        errors++;
        $display("FAIL simul_model t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, kif.valid,
                 kif.pressed, kif.multi, kif.code, e_valid, e_pressed, e_multi, e_code);
      end
      if (kif.valid === 1'b1) begin
        strobes++;
        checks++;
        if (kif.code !== 4'd4 || kif.multi !== 1'b1) begin
          errors++;
          $display("FAIL simul_strobe got code=%0d multi=%b want code=4 multi=1", kif.code, kif.multi);
        end
      end
    end
    checks++;
    if (strobes != 1) begin
      errors++;
      $display("FAIL simul_count got %0d strobes want 1", strobes);
    end
  endtask

  task automatic test_hold_release();
    int strobes = 0;
    logic [NKEYS-1:0] k;
    for (int t = 0; t < 73; t++) begin
      if (t < 50 || t == 52) k = 10'h200;
      else if (t >= 58 && t < 66) k = 10'h002;
      else k = 10'h000;
      tick(k, 1'b1, 1'b0);
      checks++;
      if ({kif.valid, kif.pressed, kif.multi, kif.code} !== {e_valid, e_pressed, e_multi, e_code}) begin
        errors++;
        $display("FAIL hold_model t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, kif.valid,
                 kif.pressed, kif.multi, kif.code, e_valid, e_pressed, e_multi, e_code);
      end
      if (kif.valid === 1'b1) begin
        strobes++;
        checks++;
        if (kif.code !== ((strobes == 1) ? 4'd9 : 4'd1)) begin
          errors++;
          $display("FAIL hold_code strobe=%0d got code=%0d", strobes, kif.code);
        end
      end
      if (t == 54 || t == 55) begin
        checks++;
        if (kif.pressed !== (t == 54)) begin
          errors++;
          $display("FAIL hold_release t=%0d got pressed=%b want %b", t, kif.pressed, t == 54);
        end
      end
    end
    checks++;
    if (strobes != 2) begin
      errors++;
      $display("FAIL hold_count got %0d strobes want 2", strobes);
    end
  endtask

  task automatic test_enable();
    int strobes = 0;
    logic en;
    logic [NKEYS-1:0] k;
    for (int t = 0; t < 22; t++) begin
      en = (t >= 5 && t <= 6) || (t >= 10 && t <= 14);
      k  = (t < 16) ? 10'h001 : 10'h000;
      tick(k, en, 1'b0);
      checks++;
      if ({kif.valid, kif.pressed, kif.multi, kif.code} !== {e_valid, e_pressed, e_multi, e_code}) begin
        errors++;
        $display("FAIL enable_model t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, kif.valid,
                 kif.pressed, kif.multi, kif.code, e_valid, e_pressed, e_multi, e_code);
      end
      if (kif.valid === 1'b1) strobes++;
      if (t < 5 || t == 7 || t == 18) begin
        checks++;
        if (kif.pressed !== 1'b0) begin
          errors++;
          $display("FAIL enable_idle t=%0d got pressed=%b want 0", t, kif.pressed);
        end
      end
    end
    checks++;
    if (strobes != 1) begin
      errors++;
      $display("FAIL enable_count got %0d strobes want 1", strobes);
    end
  endtask

  task automatic test_clear();
    int strobes = 0;
    logic clr;
    for (int t = 0; t < 22; t++) begin
      clr = (t == 1 || t == 8);
      tick((t < 16) ? 10'h008 : 10'h000, 1'b1, clr);
      checks++;
      if ({kif.valid, kif.pressed, kif.multi, kif.code} !== {e_valid, e_pressed, e_multi, e_code}) begin
        errors++;
        $display("FAIL clear_model t=%0d got %b%b%b/%0d want %b%b%b/%0d", t, kif.valid,
                 kif.pressed, kif.multi, kif.code, e_valid, e_pressed, e_multi, e_code);
      end
      if (clr) begin
        checks++;
        if ({kif.valid, kif.pressed, kif.multi, kif.code} !== 7'd0) begin
          errors++;
          $display("FAIL clear_outputs t=%0d got v=%b p=%b m=%b c=%0d want all zero",
                   t, kif.valid, kif.pressed, kif.multi, kif.code);
        end
      end
      if (kif.valid === 1'b1) begin
        strobes++;
        checks++;
        if ((t != 5 && t != 12) || kif.code !== 4'd3) begin
          errors++;
          $display("FAIL clear_strobe t=%0d code=%0d want t=5/12 code=3", t, kif.code);
        end
      end
    end
    checks++;
    if (strobes != 2) begin
      errors++;
      $display("FAIL clear_count got %0d strobes want 2", strobes);
    end
  endtask

  task automatic test_random();
    logic [NKEYS-1:0] k;
    logic en, clr;
    int len;
    for (int seg = 0; seg < 500; seg++) begin
      case ($urandom_range(0, 3))
        0:       k = '0;
        1:       k = NKEYS'(1) << $urandom_range(0, NKEYS - 1);
        2:       k = (NKEYS'(1) << $urandom_range(0, NKEYS - 1)) | (NKEYS'(1) << $urandom_range(0, NKEYS - 1));
        default: k = NKEYS'($urandom);
      endcase
      en  = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 8);
      for (int t = 0; t < len; t++) begin
        clr = ($urandom_range(0, 63) == 0);
        tick(k, en, clr);
        checks++;
        if ({kif.valid, kif.pressed, kif.multi, kif.code} !== {e_valid, e_pressed, e_multi, e_code}) begin
          errors++;
          $display("FAIL random seg=%0d keys=%h got %b%b%b/%0d want %b%b%b/%0d", seg, k, kif.valid,
                   kif.pressed, kif.multi, kif.code, e_valid, e_pressed, e_multi, e_code);
        end
      end
    end
    for (int t = 0; t < 8; t++) tick(10'h000, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    kif.keys   = '0;
    kif.enable = 1'b0;
    clear      = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_hold_release();
    test_enable();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_debounce_ctrl.md
Name: keypad_debounce_ctrl

Overview:
Controller for the microwave keypad front end. It sequences the key-settle delay that feeds the digit encoder, debounces the raw key lines and arbitrates simultaneous presses by fixed priority. It emits one encoded digit with a single-cycle strobe per press, then blocks until release. It sits between the raw keypad inputs and the display/time-entry logic.

Parameters:
NKEYS, 10, number of key lines (1..16); key i encodes to digit i.
DEBOUNCE, 3, number of consecutive matching samples required for press and for release (>=1).

Ports:
clk  input  1  system clock; all logic on posedge.
clear  input  1  synchronous, active-high reset.
enable  input  1  accept new presses when 1.
keys  input  NKEYS  raw key lines, 1 = pressed; assumed already synchronised upstream.
code  output  4  encoded digit of the last accepted press.
valid  output  1  one-cycle strobe; code is new in this cycle.
pressed  output  1  1 while a press is being qualified or held (state != IDLE).
multi  output  1  1 if the accepted sample had more than one key set; updated with code.

Behaviour:
- All outputs registered. On clear at a posedge: state=IDLE, code=0, valid=0, pressed=0, multi=0, internal sample register=0, count=0. clear has priority over every other input.
- Internal count width: ceil(log2(DEBOUNCE+1)); it never wraps because it is reset at each state change.
- IDLE: if enable=1 and keys!=0 at a posedge -> sample<=keys, count<=0, go to DEBOUNCE (capture edge). Otherwise stay in IDLE.
- DEBOUNCE: at each posedge:
  - enable=0 or keys!=sample -> IDLE, no output, count<=0.
  - else if count==DEBOUNCE-1 -> EMIT, valid<=1, code<=index of lowest set bit of sample, multi<=(popcount(sample)>1).
  - else count<=count+1.
- EMIT: lasts exactly one cycle. At the next posedge valid<=0, count<=0, go to WAIT_RELEASE. This transition is unconditional and independent of keys and enable.
- WAIT_RELEASE: at each posedge:
  - keys!=0 -> count<=0.
  - else if count==DEBOUNCE-1 -> IDLE.
  - else count<=count+1.
  - enable is ignored in this state, so a held key never re-triggers.
- Latency: with keys stable from capture edge E0, valid=1 between edge E0+DEBOUNCE and E0+DEBOUNCE+1. Release completes DEBOUNCE edges after the first all-zero sample.
- pressed<=1 on the edge entering DEBOUNCE and stays 1 through EMIT and WAIT_RELEASE. It is <=0 on the edge returning to IDLE.
- Priority: lowest key index wins (key 0 highest). Any change of the key pattern during DEBOUNCE, including an added or removed second key, restarts qualification from IDLE.
- Key bits at index >= NKEYS do not exist. Codes are always < NKEYS.
- clear asserted mid-DEBOUNCE or mid-WAIT_RELEASE: return to IDLE next edge, no strobe emitted. A key still held after clear is treated as a new press.
- code and multi hold their value between strobes.

Test Plan:
1. Reset, DEBOUNCE=3: keys=0x020 held 10 cycles -> valid high exactly one cycle, 3 edges after capture; code=5, multi=0, pressed=1 until release qualifies.
2. Bounce: keys=0x004 for 2 cycles, 0 for 1 cycle, then 0x004 stable -> no strobe for the first burst; a single strobe with code=2 after the stable press qualifies.
3. Simultaneous: keys=0x090 (keys 4 and 7) stable -> code=4, multi=1, one strobe.
4. Hold and release: key 9 held 50 cycles -> one strobe only. Release with a 1-cycle re-bounce at release count 2 -> pressed drops only after 3 consecutive zero samples. A new press of key 1 then yields code=1.
5. enable=0 with keys=0x001 -> no capture, pressed=0. Drop enable mid-DEBOUNCE -> abort with no strobe. Drop enable during WAIT_RELEASE -> release still completes.
6. Assert clear one cycle during DEBOUNCE and again during WAIT_RELEASE -> all outputs 0 next cycle, code reset to 0. A held key re-qualifies and strobes DEBOUNCE edges after the re-capture.
